// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with edge-detected capture and FWFT read port
module uart_rx_fifo #(
    parameter int WIDTH_SIZE = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Rx_valid,
    input  logic [WIDTH_SIZE-1:0]         Rx_data,
    input  logic                          Rx_err,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [WIDTH_SIZE-1:0]         rd_data,
    output logic                          rd_err,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic                          overflow,
    input  logic                          ovf_clear
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH_SIZE:0]  mem [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W:0]      cnt;
    logic                 rv_d;
    logic                 ovf;
    logic                 push;
    logic                 pop;
    logic                 wr_en;
    logic                 drop;

    assign push  = Rx_valid & ~rv_d;
    assign pop   = rd_valid & rd_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    assign empty       = (cnt == '0);
    assign full        = (cnt == (ADDR_W+1)'(DEPTH));
    assign almost_full = (cnt >= (ADDR_W+1)'(AFULL_LVL));
    assign count       = cnt;
    assign overflow    = ovf;
    assign rd_valid    = ~empty;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (!empty) begin
            {rd_err, rd_data} = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {Rx_err, Rx_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rv_d   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            rv_d <= Rx_valid;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (wr_en && !pop) begin
                cnt <= cnt + (ADDR_W+1)'(1);
            end else if (pop && !wr_en) begin
                cnt <= cnt - (ADDR_W+1)'(1);
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clear) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         Rx_valid = 1'b0;
    logic [W-1:0] Rx_data = '0;
    logic         Rx_err = 1'b0;
    logic         rd_ready = 1'b0;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         rd_err;
    logic [4:0]   count;
    logic         empty;
    logic         full;
    logic         almost_full;
    logic         overflow;
    logic         ovf_clear = 1'b0;

    int total = 0;
    int bad = 0;
    logic [W:0] exp_q[$];
    logic       ovf_m = 1'b0;

    uart_rx_fifo #(.WIDTH_SIZE(W), .DEPTH(DEPTH), .AFULL_LVL(12)) dut (
        .clk(clk), .reset(reset), .Rx_valid(Rx_valid), .Rx_data(Rx_data),
        .Rx_err(Rx_err), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err), .count(count), .empty(empty),
        .full(full), .almost_full(almost_full), .overflow(overflow),
        .ovf_clear(ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input logic e);
        Rx_valid = 1'b1;
        Rx_data  = d;
        Rx_err   = e;
        tick();
        if (exp_q.size() < DEPTH) exp_q.push_back({e, d});
        else ovf_m = 1'b1;
        Rx_valid = 1'b0;
        check("push_count", 32'(count), 32'(exp_q.size()));
        check("push_rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
        check("push_overflow", 32'(overflow), 32'(ovf_m));
        tick();
    endtask

    task automatic pop();
        logic [W:0] e;
        e = exp_q.pop_front();
        check("pop_valid", 32'(rd_valid), 32'd1);
        check("pop_data", 32'(rd_data), 32'(e[W-1:0]));
        check("pop_err", 32'(rd_err), 32'(e[W]));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("pop_count", 32'(count), 32'(exp_q.size()));
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        // 1: reset/idle state
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("idle_ready_count", 32'(count), 32'd0);

        // 2: two words, one with error flag
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b1);
        check("two_count", 32'(count), 32'd2);
        pop();
        pop();

        // 3: Rx_valid held high yields a single entry
        Rx_valid = 1'b1;
        Rx_data  = 8'h11;
        Rx_err   = 1'b0;
        repeat (5) tick();
        Rx_valid = 1'b0;
        tick();
        exp_q.push_back({1'b0, 8'h11});
        check("hold_count", 32'(count), 32'd1);
        pop();

        // 4: fill, overflow, drain, clear
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(i), 1'b0);
            check("fill_afull", 32'(almost_full), 32'(i + 1 >= 12));
            check("fill_full", 32'(full), 32'(i + 1 == DEPTH));
        end
        push(8'hFF, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) pop();
        check("drain_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        ovf_m = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);

        // 5: push and pop together while full, then while empty
        for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i), 1'b0);
        check("full5", 32'(full), 32'd1);
        check("full5_head", 32'(rd_data), 32'(exp_q[0][W-1:0]));
        void'(exp_q.pop_front());
        exp_q.push_back({1'b0, 8'h77});
        Rx_valid = 1'b1;
        Rx_data  = 8'h77;
        rd_ready = 1'b1;
        tick();
        Rx_valid = 1'b0;
        rd_ready = 1'b0;
        check("fullpp_count", 32'(count), 32'd16);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        tick();
        for (int i = 0; i < DEPTH; i++) pop();
        check("emptypp_valid", 32'(rd_valid), 32'd0);
        Rx_valid = 1'b1;
        Rx_data  = 8'h5A;
        rd_ready = 1'b1;
        tick();
        Rx_valid = 1'b0;
        rd_ready = 1'b0;
        exp_q.push_back({1'b0, 8'h5A});
        check("emptypp_count", 32'(count), 32'd1);
        tick();
        pop();

        // 6: pointer wrap with interleaved traffic, then reset mid-stream
        for (int i = 0; i < 3; i++) push(8'(8'hC0 + i), 1'(i & 1));
        for (int i = 0; i < 40; i++) begin
            push(8'(i * 7 + 3), 1'(i % 3 == 0));
            pop();
        end
        check("wrap_count", 32'(count), 32'd3);
        reset = 1'b1;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_valid", 32'(rd_valid), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_empty", 32'(empty), 32'd1);
        push(8'h9E, 1'b1);
        pop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
